// File: rtl/stim_compare_engine_if.sv
// rtl/stim_compare_engine_if.sv - controller/design-pair bus of the stimulus-and-compare engine
// STIM_COMPARE_MASK_EN adds the cmp_mask compare-exclusion bus.
interface stim_compare_engine_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             start;
   logic             dut_rst;
   logic [WIDTH-1:0] stim;
   logic [WIDTH-1:0] golden;
   logic [WIDTH-1:0] netlist;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [CNT_W-1:0] first_fail_idx;
`ifdef STIM_COMPARE_MASK_EN
   logic [WIDTH-1:0] cmp_mask;

   modport master (
      input  start, golden, netlist, cmp_mask,
      output dut_rst, stim, busy, done, pass, mismatch_cnt, first_fail_idx
   );
   modport slave (
      output start, golden, netlist, cmp_mask,
      input  dut_rst, stim, busy, done, pass, mismatch_cnt, first_fail_idx
   );
`else
   modport master (
      input  start, golden, netlist,
      output dut_rst, stim, busy, done, pass, mismatch_cnt, first_fail_idx
   );
   modport slave (
      output start, golden, netlist,
      input  dut_rst, stim, busy, done, pass, mismatch_cnt, first_fail_idx
   );
`endif
endinterface

// File: rtl/stim_compare_engine.sv
// rtl/stim_compare_engine.sv - reset phase + LFSR vector stream into a golden/netlist pair, with compare and result capture
// STIM_COMPARE_MASK_EN enables masked compares through bus.cmp_mask.
module stim_compare_engine #(
   parameter int          WIDTH       = 32,
   parameter int          NUM_VECTORS = 1000,
   parameter int          RST_CYCLES  = 2,
   parameter int          HOLD_CYCLES = 2,
   parameter logic [31:0] SEED        = 32'h1,
   parameter int          CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst,
   stim_compare_engine_if.master bus
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RSTPH  = 3'd1;
   localparam logic [2:0] S_APPLY  = 3'd2;
   localparam logic [2:0] S_SAMPLE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [31:0] LFSR_MASK = 32'h80200003;
   localparam logic [31:0] SEED_NZ   = (SEED == 32'h0) ? 32'h1 : SEED;

   localparam int              HMAX       = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
   localparam int              HC_W       = $clog2(HMAX + 1);
   localparam logic [HC_W-1:0] RST_LAST   = HC_W'(RST_CYCLES - 1);
   localparam logic [HC_W-1:0] APPLY_LAST = HC_W'(HOLD_CYCLES - 2);

   // With a one-cycle hold a vector lives only in SAMPLE.
   localparam logic [2:0]       VEC_ENTRY = (HOLD_CYCLES > 1) ? S_APPLY : S_SAMPLE;
   localparam logic [CNT_W-1:0] ALL_ONES  = '1;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VECTORS);

   generate
      if (NUM_VECTORS < 1 || NUM_VECTORS >= (2 ** CNT_W) - 1) begin : g_bad_num_vectors
         $error("stim_compare_engine: NUM_VECTORS must be >= 1 and < 2**CNT_W - 1");
      end
      if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
         $error("stim_compare_engine: WIDTH must be in 1..32");
      end
      if (RST_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
         $error("stim_compare_engine: RST_CYCLES and HOLD_CYCLES must be >= 1");
      end
   endgenerate

   logic [2:0]       state;
   logic [HC_W-1:0]  hold_cnt;
   logic [CNT_W-1:0] idx;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_nx;
   logic [WIDTH-1:0] stim_q;
   logic [CNT_W-1:0] mm_cnt;
   logic [CNT_W-1:0] ffi;
   logic [WIDTH-1:0] diff;
   logic             miss;
   logic             cmp_now;

   assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 32'h0);

`ifdef STIM_COMPARE_MASK_EN
   assign diff = (bus.golden ^ bus.netlist) & ~bus.cmp_mask;
`else
   assign diff = bus.golden ^ bus.netlist;
`endif
   assign miss    = |diff;
   assign cmp_now = ((state == S_RSTPH) && (hold_cnt == RST_LAST)) || (state == S_SAMPLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         idx      <= '0;
         lfsr     <= SEED_NZ;
         stim_q   <= '0;
         mm_cnt   <= '0;
         ffi      <= ALL_ONES;
      end else begin
         if (cmp_now && miss) begin
            if (mm_cnt != ALL_ONES)
               mm_cnt <= mm_cnt + 1'b1;
            if (ffi == ALL_ONES)
               ffi <= idx;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state    <= S_RSTPH;
                  hold_cnt <= '0;
                  idx      <= '0;
                  lfsr     <= SEED_NZ;
                  stim_q   <= '0;
                  mm_cnt   <= '0;
                  ffi      <= ALL_ONES;
               end
            end
            S_RSTPH: begin
               if (hold_cnt == RST_LAST) begin
                  state    <= VEC_ENTRY;
                  hold_cnt <= '0;
                  idx      <= CNT_W'(1);
                  lfsr     <= lfsr_nx;
                  stim_q   <= lfsr_nx[WIDTH-1:0];
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_APPLY: begin
               if (hold_cnt == APPLY_LAST) begin
                  state    <= S_SAMPLE;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            S_SAMPLE: begin
               if (idx < LAST_IDX) begin
                  state    <= VEC_ENTRY;
                  hold_cnt <= '0;
                  idx      <= idx + 1'b1;
                  lfsr     <= lfsr_nx;
                  stim_q   <= lfsr_nx[WIDTH-1:0];
               end else begin
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // IDLE is only reachable through reset, so the pair is kept in reset there too.
   assign bus.dut_rst        = (state == S_IDLE) || (state == S_RSTPH);
   assign bus.stim           = stim_q;
   assign bus.busy           = (state == S_RSTPH) || (state == S_APPLY) || (state == S_SAMPLE);
   assign bus.done           = (state == S_DONE);
   assign bus.pass           = (state == S_DONE) && (mm_cnt == '0);
   assign bus.mismatch_cnt   = mm_cnt;
   assign bus.first_fail_idx = ffi;
endmodule

// File: tb/tb_stim_compare_engine.sv
// tb/tb_stim_compare_engine.sv - randomized self-checking bench for stim_compare_engine
module tb_stim_compare_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   stim_compare_engine_if #(.WIDTH(32), .CNT_W(16)) a_if ();
   stim_compare_engine_if #(.WIDTH(8),  .CNT_W(2))  s_if ();
   stim_compare_engine_if #(.WIDTH(32), .CNT_W(16)) c_if ();

   stim_compare_engine #(.WIDTH(32), .NUM_VECTORS(4), .RST_CYCLES(2), .HOLD_CYCLES(2),
                         .SEED(32'h1), .CNT_W(16))
      u_a (.clk(clk), .rst(rst), .bus(a_if.master));
   stim_compare_engine #(.WIDTH(8), .NUM_VECTORS(2), .RST_CYCLES(1), .HOLD_CYCLES(3),
                         .SEED(32'hACE1), .CNT_W(2))
      u_s (.clk(clk), .rst(rst), .bus(s_if.master));
   stim_compare_engine #(.WIDTH(32), .NUM_VECTORS(20), .RST_CYCLES(3), .HOLD_CYCLES(1),
                         .SEED(32'h0), .CNT_W(16))
      u_c (.clk(clk), .rst(rst), .bus(c_if.master));

   logic        start_w  [3];
   logic        done_w   [3];
   logic        dutrst_w [3];
   logic [31:0] stim_w   [3];
   logic [31:0] seen[$];

   assign a_if.start = start_w[0];
   assign s_if.start = start_w[1];
   assign c_if.start = start_w[2];
   assign done_w[0] = a_if.done;    assign dutrst_w[0] = a_if.dut_rst;  assign stim_w[0] = a_if.stim;
   assign done_w[1] = s_if.done;    assign dutrst_w[1] = s_if.dut_rst;  assign stim_w[1] = 32'(s_if.stim);
   assign done_w[2] = c_if.done;    assign dutrst_w[2] = c_if.dut_rst;  assign stim_w[2] = c_if.stim;

   // Behavioural design copies: golden is any fixed function of stim; netlist adds injected faults.
   function automatic logic [31:0] gold32(input logic rst_in, input logic [31:0] x);
      return rst_in ? 32'h0000DEAD : ({x[15:0], x[31:16]} ^ 32'h5A5A5A5A);
   endfunction

   logic [31:0] a_perm = '0, a_fv1 = '0, a_fv2 = '0, a_mask = '0;
   assign a_if.golden  = gold32(a_if.dut_rst, a_if.stim);
   assign a_if.netlist = a_if.golden ^ a_perm
                       ^ (((!a_if.dut_rst) && (a_if.stim == a_fv1 || a_if.stim == a_fv2)) ? 32'h1 : 32'h0);

   logic [7:0] s_perm = '0;
   assign s_if.golden  = s_if.stim + 8'h3;
   assign s_if.netlist = s_if.golden ^ s_perm;

   logic [31:0] c_vec  [21];
   logic [31:0] c_fail [21];
   logic [31:0] c_fault;
   always_comb begin
      c_fault = '0;
      if (c_if.dut_rst) c_fault = c_fail[0];
      else for (int k = 1; k <= 20; k++) if (c_if.stim == c_vec[k]) c_fault = c_fail[k];
   end
   assign c_if.golden  = gold32(c_if.dut_rst, c_if.stim);
   assign c_if.netlist = c_if.golden ^ c_fault;

`ifdef STIM_COMPARE_MASK_EN
   assign a_if.cmp_mask = a_mask;
   assign s_if.cmp_mask = '0;
   assign c_if.cmp_mask = '0;
`endif

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
   endfunction

   // Expected results from the set of failing compare indices (bit i = compare i fails).
   function automatic logic [31:0] exp_cnt(input logic [31:0] flags, input int cw);
      int n   = $countones(flags);
      int sat = (1 << cw) - 1;
      return 32'((n > sat) ? sat : n);
   endfunction
   function automatic logic [31:0] exp_ffi(input logic [31:0] flags, input int cw);
      for (int i = 0; i < 32; i++) if (flags[i]) return 32'(i);
      return 32'((1 << cw) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start on engine w; return cycles from the start edge until done is seen.
   task automatic run(input int w, input int poke, output int cycles, output int rstc);
      seen.delete();
      rstc = 0;
      @(negedge clk); start_w[w] = 1'b1;
      @(negedge clk); start_w[w] = 1'b0;
      cycles = 1;
      while (!done_w[w] && cycles < 400) begin
         if (dutrst_w[w]) rstc++;
         else if (seen.size() == 0 || seen[$] != stim_w[w]) seen.push_back(stim_w[w]);
         @(negedge clk);
         cycles++;
         start_w[w] = (cycles == poke);
      end
      start_w[w] = 1'b0;
   endtask

   logic [31:0] a_vec [5];
   logic [31:0] flags;
   int cyc, rc, n;

   initial begin
      for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
      a_vec[0] = 32'h1;
      for (int k = 1; k <= 4; k++) a_vec[k] = lfsr_step(a_vec[k-1]);
      c_vec[0] = 32'h1;
      for (int k = 1; k <= 20; k++) c_vec[k] = lfsr_step(c_vec[k-1]);
      for (int k = 0; k <= 20; k++) c_fail[k] = '0;

      repeat (2) @(negedge clk);
      chk("rst_dut_rst", 32'(a_if.dut_rst), 1);
      chk("rst_stim",    a_if.stim, 0);
      chk("rst_busy",    32'(a_if.busy), 0);
      chk("rst_done",    32'(a_if.done), 0);
      chk("rst_pass",    32'(a_if.pass), 0);
      chk("rst_cnt",     32'(a_if.mismatch_cnt), 0);
      chk("rst_ffi",     32'(a_if.first_fail_idx), 32'hFFFF);
      rst = 1'b0;

      // Matching copies and LFSR sequence
      run(0, 0, cyc, rc);
      chk("a_match_cycles", 32'(cyc), 11);
      chk("a_match_rstc",   32'(rc), 2);
      chk("a_match_pass",   32'(a_if.pass), 1);
      chk("a_match_cnt",    32'(a_if.mismatch_cnt), 0);
      chk("a_match_ffi",    32'(a_if.first_fail_idx), 32'hFFFF);
      chk("a_seen_len",     32'(seen.size()), 4);
      for (int k = 1; k <= 4 && k <= seen.size(); k++) chk($sformatf("a_stim_v%0d", k), seen[k-1], a_vec[k]);
      chk("a_busy_done", 32'(a_if.busy), 0);

      // Fault on vector 3, plus a start pulse while busy
      a_fv1 = a_vec[3];
      run(0, 5, cyc, rc);
      chk("a_f3_cycles", 32'(cyc), 11);
      chk("a_f3_cnt",    32'(a_if.mismatch_cnt), 1);
      chk("a_f3_ffi",    32'(a_if.first_fail_idx), 3);
      chk("a_f3_pass",   32'(a_if.pass), 0);

      // Reset at vector 2 with a fault already counted on vector 1
      a_fv2 = a_vec[1];
      @(negedge clk); start_w[0] = 1'b1;
      @(negedge clk); start_w[0] = 1'b0;
      n = 0;
      while (!(a_if.stim == a_vec[2] && !a_if.dut_rst) && n < 50) begin @(negedge clk); n++; end
      chk("a_reach_v2",  32'(n < 50), 1);
      chk("a_mid_busy",  32'(a_if.busy), 1);
      chk("a_mid_cnt",   32'(a_if.mismatch_cnt), 1);
      rst = 1'b1;
      #1;
      chk("a_abort_dut_rst", 32'(a_if.dut_rst), 1);
      chk("a_abort_stim",    a_if.stim, 0);
      chk("a_abort_busy",    32'(a_if.busy), 0);
      chk("a_abort_done",    32'(a_if.done), 0);
      chk("a_abort_cnt",     32'(a_if.mismatch_cnt), 0);
      chk("a_abort_ffi",     32'(a_if.first_fail_idx), 32'hFFFF);
      @(negedge clk); rst = 1'b0;

      // Rerun after abort; start during the cycle DONE is entered must be ignored
      run(0, 10, cyc, rc);
      chk("a_rerun_cycles", 32'(cyc), 11);
      chk("a_rerun_cnt",    32'(a_if.mismatch_cnt), 2);
      chk("a_rerun_ffi",    32'(a_if.first_fail_idx), 1);
      repeat (3) @(negedge clk);
      chk("a_late_start_done", 32'(a_if.done), 1);
      chk("a_late_start_busy", 32'(a_if.busy), 0);
      a_fv1 = '0; a_fv2 = '0;

      // Saturation: three failing compares into a 2-bit counter, twice
      s_perm = 8'hFF;
      for (int r = 0; r < 2; r++) begin
         run(1, 0, cyc, rc);
         chk($sformatf("s_cycles_r%0d", r), 32'(cyc), 8);
         chk($sformatf("s_cnt_r%0d", r),    32'(s_if.mismatch_cnt), exp_cnt(32'h7, 2));
         chk($sformatf("s_ffi_r%0d", r),    32'(s_if.first_fail_idx), exp_ffi(32'h7, 2));
         chk($sformatf("s_pass_r%0d", r),   32'(s_if.pass), 0);
      end
      s_perm = '0;

      // Random fault sets on the zero-seed engine (one clean trial first)
      for (int t = 0; t < 5; t++) begin
         flags = (t == 0) ? 32'h0 : ($urandom & 32'h001F_FFFF);
         for (int k = 0; k <= 20; k++) c_fail[k] = flags[k] ? ($urandom | 32'h1) : 32'h0;
         run(2, 0, cyc, rc);
         chk($sformatf("c_cycles_t%0d", t), 32'(cyc), 24);
         chk($sformatf("c_first_stim_t%0d", t), (seen.size() > 0) ? seen[0] : 32'h0, c_vec[1]);
         chk($sformatf("c_cnt_t%0d", t),  32'(c_if.mismatch_cnt), exp_cnt(flags, 16));
         chk($sformatf("c_ffi_t%0d", t),  32'(c_if.first_fail_idx), exp_ffi(flags, 16));
         chk($sformatf("c_pass_t%0d", t), 32'(c_if.pass), 32'(flags == 0));
      end

`ifdef STIM_COMPARE_MASK_EN
      a_perm = 32'h1;
      a_mask = 32'h1;
      run(0, 0, cyc, rc);
      chk("m_masked_pass", 32'(a_if.pass), 1);
      chk("m_masked_cnt",  32'(a_if.mismatch_cnt), 0);
      a_mask = 32'h0;
      run(0, 0, cyc, rc);
      chk("m_open_cnt",  32'(a_if.mismatch_cnt), 5);
      chk("m_open_ffi",  32'(a_if.first_fail_idx), 0);
      chk("m_open_pass", 32'(a_if.pass), 0);
      a_perm = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
